// File: rtl/conway_scanout.sv
// conway_scanout
//   Display-side reader of the Conway accelerator's current generation buffer.
//   Follows the VGA timing counters and fetches each grid row one word ahead of
//   need. Each 20-cell word is shifted out MSB first as a 1-bit pixel stream.
//   It also emits a once-per-frame ready_sig pulse at the start of vertical
//   blanking, which the accelerator uses to time its buffer swap.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high
//   pix_en       pixel strobe; hcount/vcount advance on cycles where it is high
//   hcount       horizontal pixel counter (11 bits)
//   vcount       vertical line counter (11 bits)
//   address_b    read address {row[9:0], word[5:0]}
//   q_b          read data, valid 1 clk after address_b changes
//   pixel        current cell value (1 = live)
//   pixel_valid  visible area and streaming
//   ready_sig    one-clk pulse at the start of vertical blanking
//   underrun     sticky: a visible line started without its first word loaded
//
// States
//   IDLE   | waiting for the prefetch point of the line before a visible row
//   FETCH  | first word of the row requested, data arrives next clk
//   LOADED | first word in shreg, waiting for hcount 0 of the row's line
//   ACTIVE | shifting the row out, one cell per pix_en

module conway_scanout #(
  parameter int WORD_W        = 20,
  parameter int WORDS_PER_ROW = 64,
  parameter int ROWS          = 1024,
  parameter int H_ACTIVE      = 1280,
  parameter int V_ACTIVE      = 1024,
  parameter int V_TOTAL       = 1066,
  parameter int H_PREFETCH    = 1290
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  input  logic [10:0]       hcount,
  input  logic [10:0]       vcount,
  output logic [15:0]       address_b,
  input  logic [WORD_W-1:0] q_b,
  output logic              pixel,
  output logic              pixel_valid,
  output logic              ready_sig,
  output logic              underrun
);

  localparam logic [10:0] H_ACT     = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT     = 11'(V_ACTIVE);
  localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_PF      = 11'(H_PREFETCH);
  localparam logic [10:0] ROWS_L    = 11'(ROWS);
  localparam logic [5:0]  LAST_WORD = 6'(WORDS_PER_ROW - 1);
  localparam logic [4:0]  LAST_BIT  = 5'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, FETCH, LOADED, ACTIVE} state_t;

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] nxt;
  logic [5:0]        word_idx;
  logic [4:0]        bit_idx;
  logic [9:0]        row;
  logic              nxt_pend;

  logic              line_start_pos;
  logic [10:0]       next_row;
  logic              streaming;
  logic              do_shift;

  assign line_start_pos = (hcount == 11'd0) && (vcount < V_ACT);
  assign next_row       = (vcount == V_LAST) ? 11'd0 : vcount + 11'd1;

  // Column 0 must appear in the same clk as its pix_en, which is also the clk
  // in which LOADED hands over to ACTIVE, so LOADED at hcount 0 already streams.
  assign streaming = (state == ACTIVE) || ((state == LOADED) && line_start_pos);
  assign do_shift  = pix_en && streaming;

  assign pixel       = streaming && shreg[WORD_W-1];
  assign pixel_valid = streaming && (hcount < H_ACT) && (vcount < V_ACT);
  assign ready_sig   = !reset && pix_en && (hcount == 11'd0) && (vcount == V_ACT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      nxt       <= '0;
      word_idx  <= '0;
      bit_idx   <= '0;
      row       <= '0;
      nxt_pend  <= 1'b0;
      address_b <= '0;
      underrun  <= 1'b0;
    end else begin
      if (nxt_pend) begin
        nxt      <= q_b;
        nxt_pend <= 1'b0;
      end

      if (pix_en && line_start_pos && (state != LOADED))
        underrun <= 1'b1;

      case (state)
        IDLE: begin
          if (pix_en && (hcount == H_PF) && (next_row < ROWS_L)) begin
            address_b <= {next_row[9:0], 6'd0};
            row       <= next_row[9:0];
            state     <= FETCH;
          end
        end
        FETCH: begin
          shreg    <= q_b;
          word_idx <= '0;
          bit_idx  <= '0;
          state    <= LOADED;
        end
        LOADED: begin
          if (pix_en && line_start_pos)
            state <= ACTIVE;
        end
        ACTIVE: ;
        default: state <= IDLE;
      endcase

      // Shift path; the end-of-row IDLE below overrides the ACTIVE above.
      if (do_shift) begin
        if ((bit_idx == 5'd0) && (word_idx < LAST_WORD)) begin
          address_b <= {row, word_idx + 6'd1};
          nxt_pend  <= 1'b1;
        end
        if (bit_idx == LAST_BIT) begin
          shreg   <= nxt;
          bit_idx <= '0;
          if (word_idx == LAST_WORD)
            state <= IDLE;
          else
            word_idx <= word_idx + 6'd1;
        end else begin
          shreg   <= shreg << 1;
          bit_idx <= bit_idx + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conway_scanout.sv
// Self-checking bench for conway_scanout on a reduced raster geometry.
// The reference model derives every expected pixel directly from the memory
// array (row v, column h -> word h/20, bit 19-h%20) and tracks, per line,
// whether the previous line's prefetch point was passed without a reset.

module tb_conway_scanout;

  localparam int WW  = 20;
  localparam int WPR = 4;
  localparam int NR  = 8;
  localparam int HA  = WW * WPR;
  localparam int VA  = 8;
  localparam int VT  = 11;
  localparam int HPF = 85;
  localparam int HT  = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_en;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic [15:0] address_b;
  logic [19:0] q_b;
  logic        pixel;
  logic        pixel_valid;
  logic        ready_sig;
  logic        underrun;

  always #5 clk = ~clk;

  conway_scanout #(
    .WORD_W(WW), .WORDS_PER_ROW(WPR), .ROWS(NR), .H_ACTIVE(HA),
    .V_ACTIVE(VA), .V_TOTAL(VT), .H_PREFETCH(HPF)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
    .address_b(address_b), .q_b(q_b), .pixel(pixel), .pixel_valid(pixel_valid),
    .ready_sig(ready_sig), .underrun(underrun)
  );

  logic [19:0] mem [NR][WPR];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (v=%0d h=%0d)", tag, got, exp, vcount, hcount);
    end
  endtask

  function automatic logic [19:0] memw(input logic [15:0] a);
    int r = int'(a[15:6]);
    int w = int'(a[5:0]);
    if (r < NR && w < WPR) return mem[r][w];
    return 20'h0;
  endfunction

  function automatic logic exp_bit(input int r, input int h);
    logic [19:0] wd;
    wd = mem[r][h / WW];
    return wd[WW - 1 - (h % WW)];
  endfunction

  task automatic fill_pattern();
    for (int r = 0; r < NR; r++)
      for (int w = 0; w < WPR; w++)
        mem[r][w] = {10'(r), 6'(w), 4'hA};
    mem[5][WPR-1] = 20'h80001;
  endtask

  task automatic fill_random();
    for (int r = 0; r < NR; r++)
      for (int w = 0; w < WPR; w++)
        mem[r][w] = 20'($urandom);
  endtask

  // model state
  bit   pf_valid, line_live, exp_under, pf_edge, cand, exp_v, exp_p, exp_r;
  int   pf_row, nr;
  // bench bookkeeping
  int   frame_no, mode, cyc, addr_changes, valid_cnt, rst_left;
  bit   win_reset, reset_done;
  logic [15:0] last_addr;

  initial begin
    reset = 1'b1; pix_en = 1'b0; hcount = 11'd0; vcount = 11'(VT - 1); q_b = '0;
    fill_pattern();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_address_b", 32'(address_b), 32'h0);
    chk("rst_pixel", 32'(pixel), 32'h0);
    chk("rst_pixel_valid", 32'(pixel_valid), 32'h0);
    chk("rst_ready_sig", 32'(ready_sig), 32'h0);
    chk("rst_underrun", 32'(underrun), 32'h0);

    reset = 1'b0; pix_en = 1'b1;
    last_addr = address_b;
    pf_valid = 0; line_live = 0; exp_under = 0; pf_row = 0;
    frame_no = 0; mode = 0; cyc = 0; addr_changes = 0; valid_cnt = 0;
    rst_left = 0; win_reset = 0; reset_done = 0;

    while (frame_no < 5 && cyc < 40000) begin
      @(negedge clk);
      if (hcount == 0 && vcount < VA) cand = pf_valid && (pf_row == int'(vcount));
      else cand = line_live;
      exp_v = (hcount < HA) && (vcount < VA) && cand;
      exp_p = exp_v ? exp_bit(int'(vcount), int'(hcount)) : 1'b0;
      exp_r = !reset && pix_en && (hcount == 0) && (vcount == VA);
      chk("pixel_valid", 32'(pixel_valid), 32'(exp_v));
      chk("pixel", 32'(pixel), 32'(exp_p));
      chk("ready_sig", 32'(ready_sig), 32'(exp_r));
      chk("underrun", 32'(underrun), 32'(exp_under));
      if (pix_en && pixel_valid) valid_cnt++;

      pf_edge = 0;
      nr = (int'(vcount) == VT - 1) ? 0 : int'(vcount) + 1;
      if (reset) begin
        pf_valid = 0; line_live = 0; exp_under = 0; win_reset = 1;
      end else if (pix_en) begin
        if (hcount == 0 && vcount < VA) begin
          line_live = cand;
          if (!cand) exp_under = 1;
          pf_valid = 0;
        end
        if (hcount == HA - 1) line_live = 0;
        if (hcount == HPF && nr < NR) begin
          pf_valid = 1; pf_row = nr; pf_edge = 1;
        end
      end

      if (exp_r) begin
        if (!win_reset) begin
          chk("valid_per_frame", 32'(valid_cnt), 32'(HA * VA));
          if (frame_no > 0) chk("reads_per_frame", 32'(addr_changes), 32'(NR * WPR));
        end
        valid_cnt = 0; addr_changes = 0; win_reset = 0;
        frame_no++;
        if (frame_no >= 2) fill_random();
      end

      @(posedge clk);
      #1;
      if (address_b != last_addr) addr_changes++;
      q_b = ((address_b != last_addr) || pf_edge) ? memw(address_b) : 20'($urandom);
      last_addr = address_b;
      if (pf_edge) chk("prefetch_addr", 32'(address_b), 32'({10'(pf_row), 6'd0}));

      if (pix_en) begin
        if (hcount == HT - 1) begin
          hcount = 11'd0;
          vcount = (int'(vcount) == VT - 1) ? 11'd0 : vcount + 11'd1;
        end else begin
          hcount = hcount + 11'd1;
        end
      end

      if (frame_no == 3 && !reset_done && vcount == 2 && hcount == HPF + 5) begin
        rst_left = 2; reset_done = 1;
      end
      if (rst_left > 0) begin
        reset = 1'b1; rst_left--;
      end else begin
        reset = 1'b0;
      end

      mode = (frame_no == 1) ? 1 : ((frame_no == 2 || frame_no == 3) ? 2 : 0);
      case (mode)
        1: pix_en = (cyc % 2) == 0;
        2: pix_en = ($urandom_range(0, 3) != 0);
        default: pix_en = 1'b1;
      endcase
      cyc++;
    end

    if (frame_no < 5) chk("frame_timeout", 32'(frame_no), 32'd5);
    chk("underrun_sticky", 32'(underrun), 32'(reset_done));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
